serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_full_adder.sv | 16 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg -- shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/sum width in bits
//   state_t       : control FSM states (IDLE, RUN, DONE)
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder -- single-bit full-adder cell used as the serial datapath.
//   a, b, cin : input bits
//   s         : sum bit
//   cout      : carry-out bit
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder -- bit-serial adder: one bit per clock, LSB first, through a
// single full-adder cell. Result s = a + b + cin (mod 2^WIDTH), cout = carry
// out of the MSB.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin an addition (accepted in IDLE or DONE, ignored in RUN)
//   a, b  : operands, latched on an accepted start
//   cin   : carry-in, latched on an accepted start
//   busy  : high while the addition is running
//   done  : one-cycle pulse; s/cout valid from this cycle
//   s     : registered sum
//   cout  : registered carry-out
//   ovf   : two's-complement overflow (only with SERIAL_ADDER_OVF_EN defined)
// Optional feature macro: SERIAL_ADDER_OVF_EN
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_cout;
  logic             accept;
  logic             last_bit;

  // Start is only honoured outside RUN, so a running operation is never disturbed.
  assign accept   = start && (state != RUN);
  assign last_bit = (cnt == LAST);

  // The operand registers shift right each RUN cycle, so bit 0 is always the
  // bit currently being added.
  full_adder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state before the case, so no
  // path leaves state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: these are a handful of flops, not a memory array, so all of them
  // take the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      // s and cout are left alone here: they hold the previous result until
      // the first RUN cycle starts overwriting them.
      a_q   <= a;
      b_q   <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> 1;
      b_q   <= b_q >> 1;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      // Sum bits enter at the MSB; after WIDTH shifts the LSB has reached bit 0.
      s     <= {fa_s, s[WIDTH-1:1]};
      if (last_bit) cout <= fa_cout;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB cycle, the carry register holds the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ovf <= 1'b0;
    else if (state == RUN && last_bit)   ovf <= carry ^ fa_cout;
  end
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- self-checking bench for serial_adder (WIDTH=4).
// Table-driven directed vectors, hand-written multi-cycle sequences
// (start held during RUN, reset mid-run, back-to-back start), and random
// operations checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] s;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_s;
  logic         last_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .s    (s),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_s;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    int sx, sy, t;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    t  = sx + sy + int'(c);
    return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
  endfunction

  // Launch one operation and follow it to the DONE cycle; returns in DONE.
  // With hold set, start stays high through RUN and a is changed mid-run.
  task automatic do_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input bit hold,
                       input logic [W-1:0] exp_s, input logic exp_cout, input logic exp_ovf);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    step();
    if (!hold) start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check({name, " busy"}, busy, 1'b1);
      check({name, " done_low"}, done, 1'b0);
      if (hold && i == 1) begin
        a = 4'h9; b = ~tb_v; cin = ~tc;
      end
      step();
    end
    start = 1'b0;
    check({name, " done"}, done, 1'b1);
    check({name, " busy_low"}, busy, 1'b0);
    check({name, " s"}, s, exp_s);
    check({name, " cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
    check({name, " ovf"}, ovf, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unexpected x in ovf expectation for %s", name);
`endif
    last_s = exp_s;
    last_cout = exp_cout;
  endtask

  // One cycle after DONE with start low: back in IDLE, result held.
  task automatic idle_check(input string name);
    step();
    check({name, " idle_done"}, done, 1'b0);
    check({name, " idle_busy"}, busy, 1'b0);
    check({name, " held_s"}, s, last_s);
    check({name, " held_cout"}, cout, last_cout);
  endtask

  vec_t vecs[6];

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{a: 4'h3, b: 4'h4, cin: 1'b0, exp_s: 4'h7, exp_cout: 1'b0, exp_ovf: 1'b0};
    vecs[1] = '{a: 4'hF, b: 4'h1, cin: 1'b0, exp_s: 4'h0, exp_cout: 1'b1, exp_ovf: 1'b0};
    vecs[2] = '{a: 4'hF, b: 4'hF, cin: 1'b1, exp_s: 4'hF, exp_cout: 1'b1, exp_ovf: 1'b0};
    vecs[3] = '{a: 4'h7, b: 4'h1, cin: 1'b0, exp_s: 4'h8, exp_cout: 1'b0, exp_ovf: 1'b1};
    vecs[4] = '{a: 4'hA, b: 4'h5, cin: 1'b1, exp_s: 4'h0, exp_cout: 1'b1, exp_ovf: 1'b0};
    vecs[5] = '{a: 4'h8, b: 4'h8, cin: 1'b0, exp_s: 4'h0, exp_cout: 1'b1, exp_ovf: 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_s = '0; last_cout = 1'b0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset s", s, '0);
    check("reset cout", cout, 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Directed table; the first op starts on the first edge after release.
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0,
            vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf);
      idle_check($sformatf("vec%0d", i));
    end

    // start held through RUN with operands changed: original operands win.
    do_op("hold", 4'h3, 4'h4, 1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
    idle_check("hold");
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold single_done", done, 1'b0);
    end

    // Reset in the 2nd RUN cycle.
    a = 4'hF; b = 4'h0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #3 rst_n = 1'b0;
    #1;
    check("midreset busy", busy, 1'b0);
    check("midreset done", done, 1'b0);
    check("midreset s", s, '0);
    check("midreset cout", cout, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("midreset no_done", done, 1'b0);
      step();
    end
    do_op("post_reset", 4'h5, 4'h6, 1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
    idle_check("post_reset");

    // Back-to-back: start asserted in the DONE cycle, no IDLE in between.
    do_op("b2b_first", 4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0);
    do_op("b2b_second", 4'h2, 4'h2, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
    idle_check("b2b_second");

    // Random operations against the arithmetic model; randomly chained.
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rc = 1'($urandom_range(0, 1));
      r  = ref_sum(ra, rb, rc);
      do_op($sformatf("rand%0d", n), ra, rb, rc, 1'b0, r[W-1:0], r[W], ref_ovf(ra, rb, rc));
      if ($urandom_range(0, 1) == 0) idle_check($sformatf("rand%0d", n));
    end
    idle_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
